// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator: timing record,
// 1080p60 defaults, FSM state encoding and the colour-bar palette.
package video_timing_pkg;

  localparam int unsigned VTG_CNT_W = 13;

  localparam int unsigned H_SYNC_1080P = 44;
  localparam int unsigned H_BP_1080P   = 148;
  localparam int unsigned H_ACT_1080P  = 1920;
  localparam int unsigned H_FP_1080P   = 88;
  localparam int unsigned V_SYNC_1080P = 5;
  localparam int unsigned V_BP_1080P   = 36;
  localparam int unsigned V_ACT_1080P  = 1080;
  localparam int unsigned V_FP_1080P   = 4;

  typedef struct packed {
    logic [VTG_CNT_W-1:0] h_sync;
    logic [VTG_CNT_W-1:0] h_bp;
    logic [VTG_CNT_W-1:0] h_act;
    logic [VTG_CNT_W-1:0] h_fp;
    logic [VTG_CNT_W-1:0] v_sync;
    logic [VTG_CNT_W-1:0] v_bp;
    logic [VTG_CNT_W-1:0] v_act;
    logic [VTG_CNT_W-1:0] v_fp;
    logic                 hs_pol;
    logic                 vs_pol;
  } timing_t;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing-configuration handshake: valid/ready transfer of a full timing record.
interface video_timing_gen_if #(parameter int unsigned CNT_W = 13);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;
  logic [CNT_W-1:0] cfg_h_sync;
  logic [CNT_W-1:0] cfg_h_bp;
  logic [CNT_W-1:0] cfg_h_act;
  logic [CNT_W-1:0] cfg_h_fp;
  logic [CNT_W-1:0] cfg_v_sync;
  logic [CNT_W-1:0] cfg_v_bp;
  logic [CNT_W-1:0] cfg_v_act;
  logic [CNT_W-1:0] cfg_v_fp;
  logic             cfg_hs_pol;
  logic             cfg_vs_pol;

  modport master (
    output cfg_valid, cfg_h_sync, cfg_h_bp, cfg_h_act, cfg_h_fp,
           cfg_v_sync, cfg_v_bp, cfg_v_act, cfg_v_fp, cfg_hs_pol, cfg_vs_pol,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_h_sync, cfg_h_bp, cfg_h_act, cfg_h_fp,
           cfg_v_sync, cfg_v_bp, cfg_v_act, cfg_v_fp, cfg_hs_pol, cfg_vs_pol,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/vtg_axis_cnt.sv
// One raster axis: 0-based counter over SYNC/BP/ACT/FP with region decode.
module vtg_axis_cnt #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic [W-1:0] len_sync,
  input  logic [W-1:0] len_bp,
  input  logic [W-1:0] len_act,
  input  logic [W-1:0] len_fp,
  output logic         first_c,
  output logic         last_c,
  output logic         in_sync_c,
  output logic         in_act_c,
  output logic [W-1:0] coord_c
);

  localparam int unsigned SW = W + 2;

  logic [W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0] cnt_w, act_lo, act_hi, tot;

  // Region boundaries are summed two bits wider so no field combination overflows.
  always_comb begin
    cnt_w     = SW'(cnt_q);
    act_lo    = SW'(len_sync) + SW'(len_bp);
    act_hi    = act_lo + SW'(len_act);
    tot       = act_hi + SW'(len_fp);
    first_c   = (cnt_q == '0);
    last_c    = (cnt_w == tot - SW'(1));
    in_sync_c = (cnt_q < len_sync);
    in_act_c  = (cnt_w >= act_lo) && (cnt_w < act_hi);
    coord_c   = in_act_c ? W'(cnt_w - act_lo) : '0;
    cnt_d     = cnt_q;
    if (inc) begin
      cnt_d = last_c ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Run-time reprogrammable raster timing generator (HSYNC/VSYNC/DE/X/Y/SOL/SOF).
// Optional colour-bar test pattern on rgb when VIDEO_TIMING_COLOR_BAR_EN is defined.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned CNT_W      = VTG_CNT_W,
  parameter int unsigned DEF_H_SYNC = H_SYNC_1080P,
  parameter int unsigned DEF_H_BP   = H_BP_1080P,
  parameter int unsigned DEF_H_ACT  = H_ACT_1080P,
  parameter int unsigned DEF_H_FP   = H_FP_1080P,
  parameter int unsigned DEF_V_SYNC = V_SYNC_1080P,
  parameter int unsigned DEF_V_BP   = V_BP_1080P,
  parameter int unsigned DEF_V_ACT  = V_ACT_1080P,
  parameter int unsigned DEF_V_FP   = V_FP_1080P,
  parameter logic        DEF_HS_POL = 1'b1,
  parameter logic        DEF_VS_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  video_timing_gen_if.slave cfg,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             sol,
  output logic             sof,
  output logic             busy
`ifdef VIDEO_TIMING_COLOR_BAR_EN
  ,
  output logic [23:0]      rgb
`endif
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;

  localparam timing_t DEF_TIMING = '{
    h_sync: VTG_CNT_W'(DEF_H_SYNC), h_bp: VTG_CNT_W'(DEF_H_BP),
    h_act:  VTG_CNT_W'(DEF_H_ACT),  h_fp: VTG_CNT_W'(DEF_H_FP),
    v_sync: VTG_CNT_W'(DEF_V_SYNC), v_bp: VTG_CNT_W'(DEF_V_BP),
    v_act:  VTG_CNT_W'(DEF_V_ACT),  v_fp: VTG_CNT_W'(DEF_V_FP),
    hs_pol: DEF_HS_POL,             vs_pol: DEF_VS_POL
  };

  logic [1:0]       state_q, state_d;
  timing_t          shadow_q, shadow_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic             sol_q, sol_d, sof_q, sof_d, busy_q, busy_d, cfg_err_q, cfg_err_d;

  logic             h_first_c, h_last_c, h_sync_c, h_act_c;
  logic             v_first_c, v_last_c, v_sync_c, v_act_c;
  logic [CNT_W-1:0] h_coord_c, v_coord_c;
  logic             run_c, frame_last_c, xfer_c, cfg_zero_c;

  vtg_axis_cnt #(.W(CNT_W)) u_h_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (run_c),
    .len_sync  (CNT_W'(shadow_q.h_sync)),
    .len_bp    (CNT_W'(shadow_q.h_bp)),
    .len_act   (CNT_W'(shadow_q.h_act)),
    .len_fp    (CNT_W'(shadow_q.h_fp)),
    .first_c   (h_first_c),
    .last_c    (h_last_c),
    .in_sync_c (h_sync_c),
    .in_act_c  (h_act_c),
    .coord_c   (h_coord_c)
  );

  vtg_axis_cnt #(.W(CNT_W)) u_v_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (run_c && h_last_c),
    .len_sync  (CNT_W'(shadow_q.v_sync)),
    .len_bp    (CNT_W'(shadow_q.v_bp)),
    .len_act   (CNT_W'(shadow_q.v_act)),
    .len_fp    (CNT_W'(shadow_q.v_fp)),
    .first_c   (v_first_c),
    .last_c    (v_last_c),
    .in_sync_c (v_sync_c),
    .in_act_c  (v_act_c),
    .coord_c   (v_coord_c)
  );

  assign run_c         = (state_q != IDLE);
  assign frame_last_c  = run_c && h_last_c && v_last_c;
  assign cfg.cfg_ready = (state_q == IDLE) || frame_last_c;
  assign xfer_c        = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_zero_c    = (cfg.cfg_h_sync == '0) || (cfg.cfg_h_bp == '0) ||
                         (cfg.cfg_h_act  == '0) || (cfg.cfg_h_fp == '0) ||
                         (cfg.cfg_v_sync == '0) || (cfg.cfg_v_bp == '0) ||
                         (cfg.cfg_v_act  == '0) || (cfg.cfg_v_fp == '0);

  // Next state, shadow capture and output decode of the current counter position.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    cfg_err_d = 1'b0;
    hsync_d   = ~shadow_q.hs_pol;
    vsync_d   = ~shadow_q.vs_pol;
    de_d      = 1'b0;
    pix_x_d   = '0;
    pix_y_d   = '0;
    sol_d     = 1'b0;
    sof_d     = 1'b0;
    busy_d    = run_c;

    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = frame_last_c ? IDLE : DRAIN;
      DRAIN:   if (frame_last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A zero-length field would break the raster; keep the old timing and flag it.
    if (xfer_c) begin
      if (cfg_zero_c) begin
        cfg_err_d = 1'b1;
      end else begin
        shadow_d = '{
          h_sync: VTG_CNT_W'(cfg.cfg_h_sync), h_bp: VTG_CNT_W'(cfg.cfg_h_bp),
          h_act:  VTG_CNT_W'(cfg.cfg_h_act),  h_fp: VTG_CNT_W'(cfg.cfg_h_fp),
          v_sync: VTG_CNT_W'(cfg.cfg_v_sync), v_bp: VTG_CNT_W'(cfg.cfg_v_bp),
          v_act:  VTG_CNT_W'(cfg.cfg_v_act),  v_fp: VTG_CNT_W'(cfg.cfg_v_fp),
          hs_pol: cfg.cfg_hs_pol,             vs_pol: cfg.cfg_vs_pol
        };
      end
    end

    if (run_c) begin
      hsync_d = ~(h_sync_c ^ shadow_q.hs_pol);
      vsync_d = ~(v_sync_c ^ shadow_q.vs_pol);
      de_d    = h_act_c && v_act_c;
      pix_x_d = de_d ? h_coord_c : '0;
      pix_y_d = de_d ? v_coord_c : '0;
      sol_d   = h_first_c;
      sof_d   = h_first_c && v_first_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shadow_q  <= DEF_TIMING;
      hsync_q   <= ~DEF_HS_POL;
      vsync_q   <= ~DEF_VS_POL;
      de_q      <= 1'b0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      sol_q     <= 1'b0;
      sof_q     <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      sol_q     <= sol_d;
      sof_q     <= sof_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign sol         = sol_q;
  assign sof         = sof_q;
  assign busy        = busy_q;
  assign cfg.cfg_err = cfg_err_q;

`ifdef VIDEO_TIMING_COLOR_BAR_EN
  logic [23:0]      rgb_q, rgb_d;
  logic [CNT_W-1:0] bar_w_c;
  logic [2:0]       bar_idx_c;

  // Bar index is the highest i with x >= i*bar_w, so bar 7 absorbs the remainder.
  always_comb begin
    bar_w_c   = CNT_W'(shadow_q.h_act >> 3);
    bar_idx_c = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_coord_c >= CNT_W'(i) * bar_w_c) bar_idx_c = 3'(i);
    end
    rgb_d = (run_c && h_act_c && v_act_c) ? bar_rgb(bar_idx_c) : 24'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst) rgb_q <= 24'h0;
    else      rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a frame-position reference model queues
// the expected outputs each clock and a negedge monitor compares them.
module tb_video_timing_gen;

  localparam int W = 13;

  typedef struct packed {
    logic         hs;
    logic         vs;
    logic         de;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sol;
    logic         sof;
    logic         busy;
    logic         err;
    logic         rdy;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         hsync, vsync, de, sol, sof, busy;
  logic [W-1:0] pix_x, pix_y;
`ifdef VIDEO_TIMING_COLOR_BAR_EN
  logic [23:0]  rgb;
`endif

  video_timing_gen_if #(.CNT_W(W)) cfg_bus ();

  video_timing_gen dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .cfg   (cfg_bus),
    .hsync (hsync),
    .vsync (vsync),
    .de    (de),
    .pix_x (pix_x),
    .pix_y (pix_y),
    .sol   (sol),
    .sof   (sof),
    .busy  (busy)
`ifdef VIDEO_TIMING_COLOR_BAR_EN
    ,
    .rgb   (rgb)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  obs_t exp_q[$];

  // Reference model: one linear position per frame, timings as plain integers.
  int m_mode = 0;  // 0 idle, 1 run, 2 drain
  int m_pos  = 0;
  int t_hs, t_hb, t_ha, t_hf, t_vs, t_vb, t_va, t_vf;
  bit t_hp, t_vp;

  function automatic int h_total();
    return t_hs + t_hb + t_ha + t_hf;
  endfunction

  function automatic int v_total();
    return t_vs + t_vb + t_va + t_vf;
  endfunction

  always @(posedge clk) begin : model_p
    obs_t e;
    int   h, v, nmode;
    bit   fl, rdy, take, bad;
    e = '0;
    if (!rst) begin
      t_hs = 44; t_hb = 148; t_ha = 1920; t_hf = 88;
      t_vs = 5;  t_vb = 36;  t_va = 1080; t_vf = 4;
      t_hp = 1'b1; t_vp = 1'b1;
      m_mode = 0; m_pos = 0;
      e.hs = 1'b0; e.vs = 1'b0; e.rdy = 1'b1;
    end else begin
      h = m_pos % h_total();
      v = m_pos / h_total();
      if (m_mode == 0) begin
        e.hs = !t_hp;
        e.vs = !t_vp;
      end else begin
        e.hs   = ((h < t_hs) == t_hp);
        e.vs   = ((v < t_vs) == t_vp);
        e.de   = (h >= t_hs + t_hb) && (h < t_hs + t_hb + t_ha) &&
                 (v >= t_vs + t_vb) && (v < t_vs + t_vb + t_va);
        if (e.de) begin
          e.x = W'(h - t_hs - t_hb);
          e.y = W'(v - t_vs - t_vb);
        end
        e.sol  = (h == 0);
        e.sof  = (m_pos == 0);
        e.busy = 1'b1;
      end
      fl   = (m_mode != 0) && (m_pos == h_total() * v_total() - 1);
      rdy  = (m_mode == 0) || fl;
      take = cfg_bus.cfg_valid && rdy;
      bad  = take && (cfg_bus.cfg_h_sync == 0 || cfg_bus.cfg_h_bp == 0 ||
                      cfg_bus.cfg_h_act == 0 || cfg_bus.cfg_h_fp == 0 ||
                      cfg_bus.cfg_v_sync == 0 || cfg_bus.cfg_v_bp == 0 ||
                      cfg_bus.cfg_v_act == 0 || cfg_bus.cfg_v_fp == 0);
      e.err = bad;
      nmode = m_mode;
      if (m_mode == 0 && en) nmode = 1;
      else if (m_mode == 1 && !en) nmode = fl ? 0 : 2;
      else if (m_mode == 2 && fl) nmode = 0;
      if (m_mode != 0) m_pos = fl ? 0 : m_pos + 1;
      m_mode = nmode;
      if (take && !bad) begin
        t_hs = int'(cfg_bus.cfg_h_sync); t_hb = int'(cfg_bus.cfg_h_bp);
        t_ha = int'(cfg_bus.cfg_h_act);  t_hf = int'(cfg_bus.cfg_h_fp);
        t_vs = int'(cfg_bus.cfg_v_sync); t_vb = int'(cfg_bus.cfg_v_bp);
        t_va = int'(cfg_bus.cfg_v_act);  t_vf = int'(cfg_bus.cfg_v_fp);
        t_hp = cfg_bus.cfg_hs_pol;       t_vp = cfg_bus.cfg_vs_pol;
      end
      e.rdy = (m_mode == 0) || (m_pos == h_total() * v_total() - 1);
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor_p
    obs_t a, e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{hs: hsync, vs: vsync, de: de, x: pix_x, y: pix_y, sol: sol, sof: sof,
            busy: busy, err: cfg_bus.cfg_err, rdy: cfg_bus.cfg_ready};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d got hs/vs/de=%b%b%b x=%0d y=%0d sol/sof/busy/err/rdy=%b%b%b%b%b want hs/vs/de=%b%b%b x=%0d y=%0d sol/sof/busy/err/rdy=%b%b%b%b%b",
                 cyc, a.hs, a.vs, a.de, a.x, a.y, a.sol, a.sof, a.busy, a.err, a.rdy,
                 e.hs, e.vs, e.de, e.x, e.y, e.sol, e.sof, e.busy, e.err, e.rdy);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input int hs, hb, ha, hf, vs, vb, va, vf, input bit hp, vp);
    cfg_bus.cfg_h_sync = W'(hs); cfg_bus.cfg_h_bp = W'(hb);
    cfg_bus.cfg_h_act  = W'(ha); cfg_bus.cfg_h_fp = W'(hf);
    cfg_bus.cfg_v_sync = W'(vs); cfg_bus.cfg_v_bp = W'(vb);
    cfg_bus.cfg_v_act  = W'(va); cfg_bus.cfg_v_fp = W'(vf);
    cfg_bus.cfg_hs_pol = hp;     cfg_bus.cfg_vs_pol = vp;
  endtask

  // Hold cfg_valid until the handshake completes, within a cycle budget.
  task automatic offer(input int hs, hb, ha, hf, vs, vb, va, vf, input bit hp, vp,
                       input int budget);
    bit acc = 1'b0;
    drive_cfg(hs, hb, ha, hf, vs, vb, va, vf, hp, vp);
    cfg_bus.cfg_valid = 1'b1;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      acc = cfg_bus.cfg_ready;
    end
    @(posedge clk);
    #1 cfg_bus.cfg_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL cfg_accept got ready=0 within %0d cycles, want ready=1", budget);
    end
  endtask

  task automatic wait_sof(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = sof;
    end
    @(posedge clk);
    #1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sof_wait got no sof within %0d cycles, want sof=1", budget);
    end
  endtask

  initial begin
    int  f[8];
    bit  offering, accept;
    int  wait_cnt;
    cfg_bus.cfg_valid = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    step(3);
    rst = 1'b1;
    step(3);

    // 1080p defaults for two lines and a bit
    en = 1'b1;
    step(4500);

    // Abort mid-frame
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    en  = 1'b0;
    step(2);

    // Small timing loaded in IDLE, then run three frames
    offer(2, 3, 8, 2, 1, 2, 4, 1, 1'b0, 1'b0, 10);
    en = 1'b1;
    step(360);

    // Retime while running: accepted only on frame_last
    offer(2, 3, 4, 2, 1, 2, 4, 1, 1'b0, 1'b0, 200);
    step(200);

    // Stop at line 2: frame completes, then idle
    wait_sof(200);
    step(22);
    en = 1'b0;
    step(150);

    // Zero field rejected, old timing kept
    offer(2, 3, 0, 2, 1, 2, 4, 1, 1'b1, 1'b1, 10);
    step(20);
    en = 1'b1;
    step(100);

    // Randomised en toggling and config offers
    offering = 1'b0;
    wait_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      accept = offering && cfg_bus.cfg_ready;
      @(posedge clk);
      #1;
      if (accept) begin
        cfg_bus.cfg_valid = 1'b0;
        offering = 1'b0;
        checks++;
      end else if (offering) begin
        wait_cnt++;
        if (wait_cnt > 600) begin
          checks++;
          errors++;
          $display("FAIL cfg_accept_rand got ready=0 within 600 cycles, want ready=1");
          cfg_bus.cfg_valid = 1'b0;
          offering = 1'b0;
        end
      end
      if (!offering && $urandom_range(31) == 0) begin
        for (int k = 0; k < 8; k++) f[k] = int'($urandom_range(4, 1));
        if ($urandom_range(7) == 0) f[$urandom_range(7)] = 0;
        drive_cfg(f[0], f[1], f[2], f[3], f[4], f[5], f[6], f[7],
                  1'($urandom_range(1)), 1'($urandom_range(1)));
        cfg_bus.cfg_valid = 1'b1;
        offering = 1'b1;
        wait_cnt = 0;
      end
      if ($urandom_range(63) == 0) en = !en;
    end
    cfg_bus.cfg_valid = 1'b0;

    // Reset mid-frame restores the 1080p timing
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    en  = 1'b1;
    step(2300);

    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
